axi_burst_ram: RTL and testbench

AXI4 burst slave that terminates the MicroBlaze system's 32-bit `M00_AXI_0` master port in on-chip block RAM. It sits directly downstream of `system_wrapper`. It gives the processor a deterministic memory target for bring-up of the memory path before the DRAM controller is attached, and it is a port-for-port drop-in for that controller. It serves one burst at a time (read or write), with full-throughput beats and `AXI4 INCR`/`FIXED` bursts.

---
 rtl/axi_burst_ram_pkg.sv | 18 +
 rtl/axi_burst_addr_gen.sv | 49 ++++
 rtl/axi_burst_ram.sv | 216 +++++++++++++++++++++
 tb/tb_axi_burst_ram.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_burst_ram_pkg.sv
// Shared constants and FSM state type for the AXI4 burst block-RAM slave.
package axi_burst_ram_pkg;

   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [1:0] BURST_WRAP  = 2'b10;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WR_DATA = 2'd1,
      WR_RESP = 2'd2,
      RD_DATA = 2'd3
   } state_t;

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Combinational next-beat address and burst legality check, shared by the
// read and write paths. WRAP support is compiled in with AXI_BURST_RAM_WRAP_EN;
// without it every WRAP burst is flagged as an error.
module axi_burst_addr_gen
   import axi_burst_ram_pkg::*;
(
   input  logic [31:0] addr,
   input  logic [7:0]  len,
   input  logic [2:0]  size,
   input  logic [1:0]  burst,
   output logic [31:0] next_addr,
   output logic        err
);

   logic [31:0] incr;
   assign incr = 32'd1 << size;

`ifdef AXI_BURST_RAM_WRAP_EN
   logic [31:0] wrap_mask;
   logic        wrap_len_ok;
   logic        wrap_aligned;
   assign wrap_mask    = (({24'd0, len} + 32'd1) << size) - 32'd1;
   assign wrap_len_ok  = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
   assign wrap_aligned = ((addr & (incr - 32'd1)) == 32'd0);
`else
   logic unused_len;
   assign unused_len = ^len;
`endif

   // Next address per burst type; err covers size>2, reserved and illegal WRAP
   always_comb begin
      next_addr = addr;
      err       = (size > 3'd2);
      case (burst)
         BURST_FIXED: next_addr = addr;
         BURST_INCR:  next_addr = addr + incr;
         BURST_WRAP: begin
`ifdef AXI_BURST_RAM_WRAP_EN
            next_addr = (addr & ~wrap_mask) | ((addr + incr) & wrap_mask);
            if (!wrap_len_ok || !wrap_aligned) err = 1'b1;
`else
            err = 1'b1;
`endif
         end
         default: err = 1'b1;
      endcase
   end

endmodule

// File: rtl/axi_burst_ram.sv
// AXI4 burst slave backed by an inferred block RAM; one burst in flight at a
// time. Optional WRAP support: define AXI_BURST_RAM_WRAP_EN.
// INIT_FILE names the memory image handed to the implementation flow's RAM
// initialisation; the RTL itself leaves contents undefined at power-up.
module axi_burst_ram
   import axi_burst_ram_pkg::*;
#(
   parameter int ADDR_WIDTH = 12,
   parameter     INIT_FILE  = ""
) (
   input  logic        Clk,
   input  logic        rst_n,
   input  logic [31:0] s_axi_awaddr,
   input  logic [7:0]  s_axi_awlen,
   input  logic [2:0]  s_axi_awsize,
   input  logic [1:0]  s_axi_awburst,
   input  logic        s_axi_awvalid,
   output logic        s_axi_awready,
   input  logic        s_axi_awlock,
   input  logic [3:0]  s_axi_awcache,
   input  logic [2:0]  s_axi_awprot,
   input  logic [3:0]  s_axi_awqos,
   input  logic [3:0]  s_axi_awregion,
   input  logic [31:0] s_axi_wdata,
   input  logic [3:0]  s_axi_wstrb,
   input  logic        s_axi_wlast,
   input  logic        s_axi_wvalid,
   output logic        s_axi_wready,
   output logic [1:0]  s_axi_bresp,
   output logic        s_axi_bvalid,
   input  logic        s_axi_bready,
   input  logic [31:0] s_axi_araddr,
   input  logic [7:0]  s_axi_arlen,
   input  logic [2:0]  s_axi_arsize,
   input  logic [1:0]  s_axi_arburst,
   input  logic        s_axi_arvalid,
   output logic        s_axi_arready,
   input  logic        s_axi_arlock,
   input  logic [3:0]  s_axi_arcache,
   input  logic [2:0]  s_axi_arprot,
   input  logic [3:0]  s_axi_arqos,
   input  logic [3:0]  s_axi_arregion,
   output logic [31:0] s_axi_rdata,
   output logic [1:0]  s_axi_rresp,
   output logic        s_axi_rlast,
   output logic        s_axi_rvalid,
   input  logic        s_axi_rready
);

   logic [31:0] mem [2**ADDR_WIDTH];

   state_t      state_q, state_d;
   logic        idle_ok_q;     // holds off address ready until the first cycle out of reset
   logic        prefer_rd_q;   // arbitration pointer: 1 after a write was served
   logic [8:0]  beats_q;       // beats still to accept (write) or to fetch (read)
   logic        err_q;         // accept-time error: no RAM write, read data forced to 0
   logic        wlast_err_q;

   logic [31:0] addr_q;
   logic [7:0]  len_q;
   logic [2:0]  size_q;
   logic [1:0]  burst_q;

   // two-entry read skid buffer; the RAM read lands directly in an entry
   logic [31:0] skid_data_q [2];
   logic [1:0]  skid_last_q;
   logic [1:0]  skid_err_q;
   logic        skid_wr_q, skid_rd_q;
   logic [1:0]  skid_cnt_q;

   logic        aw_acc, ar_acc, w_beat, final_beat, rd_issue, r_pop;
   logic [31:0] gen_addr, next_addr;
   logic [7:0]  gen_len;
   logic [2:0]  gen_size;
   logic [1:0]  gen_burst;
   logic        gen_err;

   logic unused_ok;
   assign unused_ok = ^{s_axi_awlock, s_axi_awcache, s_axi_awprot, s_axi_awqos, s_axi_awregion,
                        s_axi_arlock, s_axi_arcache, s_axi_arprot, s_axi_arqos, s_axi_arregion};

   assign final_beat = (beats_q == 9'd1);
   assign w_beat     = s_axi_wvalid & s_axi_wready;
   assign r_pop      = s_axi_rvalid & s_axi_rready;
   assign rd_issue   = (state_q == RD_DATA) && (beats_q != 9'd0) && (skid_cnt_q != 2'd2);

   // Next state and handshake outputs; readies never gate the valids
   always_comb begin
      state_d       = state_q;
      s_axi_awready = 1'b0;
      s_axi_arready = 1'b0;
      s_axi_wready  = 1'b0;
      s_axi_bvalid  = 1'b0;
      s_axi_bresp   = RESP_OKAY;
      s_axi_rvalid  = (skid_cnt_q != 2'd0);
      s_axi_rdata   = skid_data_q[skid_rd_q];
      s_axi_rlast   = s_axi_rvalid & skid_last_q[skid_rd_q];
      s_axi_rresp   = (s_axi_rvalid & skid_err_q[skid_rd_q]) ? RESP_SLVERR : RESP_OKAY;
      aw_acc        = 1'b0;
      ar_acc        = 1'b0;
      case (state_q)
         IDLE: begin
            s_axi_awready = idle_ok_q & ~(s_axi_arvalid & prefer_rd_q);
            s_axi_arready = idle_ok_q & ~(s_axi_awvalid & ~prefer_rd_q);
            aw_acc        = s_axi_awvalid & s_axi_awready;
            ar_acc        = s_axi_arvalid & s_axi_arready;
            if (aw_acc)      state_d = WR_DATA;
            else if (ar_acc) state_d = RD_DATA;
         end
         WR_DATA: begin
            s_axi_wready = 1'b1;
            if (w_beat && final_beat) state_d = WR_RESP;
         end
         WR_RESP: begin
            s_axi_bvalid = 1'b1;
            s_axi_bresp  = (err_q | wlast_err_q) ? RESP_SLVERR : RESP_OKAY;
            if (s_axi_bready) state_d = IDLE;
         end
         RD_DATA: begin
            if (r_pop && s_axi_rlast) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Address generator sees the incoming request in IDLE, the live burst otherwise
   always_comb begin
      gen_addr  = addr_q;
      gen_len   = len_q;
      gen_size  = size_q;
      gen_burst = burst_q;
      if (state_q == IDLE) begin
         if (aw_acc) begin
            gen_addr  = s_axi_awaddr;
            gen_len   = s_axi_awlen;
            gen_size  = s_axi_awsize;
            gen_burst = s_axi_awburst;
         end else begin
            gen_addr  = s_axi_araddr;
            gen_len   = s_axi_arlen;
            gen_size  = s_axi_arsize;
            gen_burst = s_axi_arburst;
         end
      end
   end

   axi_burst_addr_gen u_addr_gen (
      .addr      (gen_addr),
      .len       (gen_len),
      .size      (gen_size),
      .burst     (gen_burst),
      .next_addr (next_addr),
      .err       (gen_err)
   );

   // Control state, beat counting, error tracking and the read skid buffer
   always_ff @(posedge Clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         idle_ok_q   <= 1'b0;
         prefer_rd_q <= 1'b0;
         beats_q     <= 9'd0;
         err_q       <= 1'b0;
         wlast_err_q <= 1'b0;
         skid_data_q[0] <= 32'd0;
         skid_data_q[1] <= 32'd0;
         skid_last_q <= 2'b00;
         skid_err_q  <= 2'b00;
         skid_wr_q   <= 1'b0;
         skid_rd_q   <= 1'b0;
         skid_cnt_q  <= 2'd0;
      end else begin
         state_q   <= state_d;
         idle_ok_q <= 1'b1;
         if (aw_acc || ar_acc) begin
            prefer_rd_q <= aw_acc;
            beats_q     <= {1'b0, gen_len} + 9'd1;
            err_q       <= gen_err;
            wlast_err_q <= 1'b0;
         end else if (w_beat || rd_issue) begin
            beats_q <= beats_q - 9'd1;
         end
         if (w_beat && (s_axi_wlast != final_beat)) wlast_err_q <= 1'b1;
         if (rd_issue) begin
            skid_data_q[skid_wr_q] <= err_q ? 32'd0 : mem[addr_q[ADDR_WIDTH+1:2]];
            skid_last_q[skid_wr_q] <= final_beat;
            skid_err_q[skid_wr_q]  <= err_q;
            skid_wr_q              <= ~skid_wr_q;
         end
         if (r_pop) skid_rd_q <= ~skid_rd_q;
         skid_cnt_q <= skid_cnt_q + {1'b0, rd_issue} - {1'b0, r_pop};
      end
   end

   // Burst address and attributes: latched on accept, stepped per beat
   always_ff @(posedge Clk) begin
      if (aw_acc || ar_acc) begin
         addr_q  <= gen_addr;
         len_q   <= gen_len;
         size_q  <= gen_size;
         burst_q <= gen_burst;
      end else if (w_beat || rd_issue) begin
         addr_q <= next_addr;
      end
   end

   // RAM write port: strobed byte lanes, suppressed for bursts rejected at accept
   always_ff @(posedge Clk) begin
      if (w_beat && !err_q) begin
         for (int b = 0; b < 4; b++) begin
            if (s_axi_wstrb[b]) mem[addr_q[ADDR_WIDTH+1:2]][8*b +: 8] <= s_axi_wdata[8*b +: 8];
         end
      end
   end

endmodule

// File: tb/tb_axi_burst_ram.sv
module tb_axi_burst_ram;
   import axi_burst_ram_pkg::*;

   localparam int TMO = 2000;

   typedef struct packed {
      logic [31:0] data;
      logic [1:0]  resp;
      logic        last;
   } rbeat_t;

   logic        Clk = 1'b0;
   logic        rst_n;
   logic [31:0] s_axi_awaddr, s_axi_araddr, s_axi_wdata, s_axi_rdata;
   logic [7:0]  s_axi_awlen, s_axi_arlen;
   logic [2:0]  s_axi_awsize, s_axi_arsize, s_axi_awprot, s_axi_arprot;
   logic [1:0]  s_axi_awburst, s_axi_arburst, s_axi_bresp, s_axi_rresp;
   logic        s_axi_awvalid, s_axi_awready, s_axi_arvalid, s_axi_arready;
   logic        s_axi_awlock, s_axi_arlock;
   logic [3:0]  s_axi_awcache, s_axi_awqos, s_axi_awregion;
   logic [3:0]  s_axi_arcache, s_axi_arqos, s_axi_arregion;
   logic [3:0]  s_axi_wstrb;
   logic        s_axi_wlast, s_axi_wvalid, s_axi_wready;
   logic        s_axi_bvalid, s_axi_bready;
   logic        s_axi_rlast, s_axi_rvalid, s_axi_rready;

   rbeat_t      exp_r[$];
   logic [1:0]  exp_b[$];
   int          n_checks = 0;
   int          n_pass   = 0;
   logic        rr_mode  = 1'b0;

   always #5 Clk = ~Clk;

   axi_burst_ram #(.ADDR_WIDTH(12)) dut (
      .Clk(Clk), .rst_n(rst_n),
      .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen), .s_axi_awsize(s_axi_awsize),
      .s_axi_awburst(s_axi_awburst), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
      .s_axi_awlock(s_axi_awlock), .s_axi_awcache(s_axi_awcache), .s_axi_awprot(s_axi_awprot),
      .s_axi_awqos(s_axi_awqos), .s_axi_awregion(s_axi_awregion),
      .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
      .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
      .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
      .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen), .s_axi_arsize(s_axi_arsize),
      .s_axi_arburst(s_axi_arburst), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
      .s_axi_arlock(s_axi_arlock), .s_axi_arcache(s_axi_arcache), .s_axi_arprot(s_axi_arprot),
      .s_axi_arqos(s_axi_arqos), .s_axi_arregion(s_axi_arregion),
      .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rlast(s_axi_rlast),
      .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   task automatic push_r(input logic [31:0] d, input logic [1:0] r, input logic l);
      rbeat_t e;
      e.data = d; e.resp = r; e.last = l;
      exp_r.push_back(e);
   endtask

   task automatic aw_req(input logic [31:0] a, input logic [7:0] l, input logic [2:0] sz, input logic [1:0] bt);
      logic hs;
      int   n;
      s_axi_awaddr = a; s_axi_awlen = l; s_axi_awsize = sz; s_axi_awburst = bt; s_axi_awvalid = 1'b1;
      hs = 1'b0; n = 0;
      while (!hs && n < TMO) begin
         @(negedge Clk); hs = s_axi_awready;
         @(posedge Clk); #1; n++;
      end
      s_axi_awvalid = 1'b0;
      check("aw_handshake", 64'(hs), 64'd1);
   endtask

   task automatic ar_req(input logic [31:0] a, input logic [7:0] l, input logic [2:0] sz, input logic [1:0] bt);
      logic hs;
      int   n;
      s_axi_araddr = a; s_axi_arlen = l; s_axi_arsize = sz; s_axi_arburst = bt; s_axi_arvalid = 1'b1;
      hs = 1'b0; n = 0;
      while (!hs && n < TMO) begin
         @(negedge Clk); hs = s_axi_arready;
         @(posedge Clk); #1; n++;
      end
      s_axi_arvalid = 1'b0;
      check("ar_handshake", 64'(hs), 64'd1);
   endtask

   task automatic w_burst(input int nb, input logic [31:0] d0, input logic [31:0] step,
                          input logic [3:0] strb, input int last_at);
      logic hs;
      int   n;
      for (int i = 0; i < nb; i++) begin
         s_axi_wdata = d0 + step * 32'(i); s_axi_wstrb = strb;
         s_axi_wlast = (i == last_at); s_axi_wvalid = 1'b1;
         hs = 1'b0; n = 0;
         while (!hs && n < TMO) begin
            @(negedge Clk); hs = s_axi_wready;
            @(posedge Clk); #1; n++;
         end
         if (!hs) begin
            check("w_handshake", 64'(hs), 64'd1);
            break;
         end
      end
      s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while ((exp_r.size() != 0 || exp_b.size() != 0) && n < TMO) begin
         @(posedge Clk); #1; n++;
      end
      check("drain", 64'(exp_r.size() + exp_b.size()), 64'd0);
   endtask

   task automatic write_burst(input logic [31:0] a, input logic [7:0] l, input logic [2:0] sz,
                              input logic [1:0] bt, input logic [31:0] d0, input logic [31:0] step,
                              input logic [3:0] strb, input int last_at, input logic [1:0] resp);
      exp_b.push_back(resp);
      aw_req(a, l, sz, bt);
      w_burst(int'(l) + 1, d0, step, strb, last_at);
      wait_drain();
   endtask

   // rready: held high, or the 1,0,0,1 backpressure pattern
   initial begin : rready_drv
      int ph;
      logic [3:0] pat;
      ph = 0; pat = 4'b1001;
      s_axi_rready = 1'b1;
      forever begin
         @(posedge Clk); #1;
         if (rr_mode) begin
            s_axi_rready = pat[ph];
            ph = (ph + 1) % 4;
         end else begin
            s_axi_rready = 1'b1;
            ph = 0;
         end
      end
   end

   // Monitor: pops expected responses on every B/R handshake, checks stall stability
   initial begin : monitor
      rbeat_t      e;
      logic        stall_q;
      logic [32:0] held;
      stall_q = 1'b0; held = '0;
      forever begin
         @(negedge Clk);
         if (!rst_n) begin
            stall_q = 1'b0;
         end else begin
            if (stall_q)
               check("r_stall_hold", {31'd0, s_axi_rvalid, s_axi_rlast, s_axi_rdata}, {31'd0, 1'b1, held});
            stall_q = s_axi_rvalid && !s_axi_rready;
            held    = {s_axi_rlast, s_axi_rdata};
            if (s_axi_bvalid && s_axi_bready) begin
               check("b_expected", 64'(exp_b.size() != 0), 64'd1);
               if (exp_b.size() != 0) check("bresp", 64'(s_axi_bresp), 64'(exp_b.pop_front()));
            end
            if (s_axi_rvalid && s_axi_rready) begin
               check("r_expected", 64'(exp_r.size() != 0), 64'd1);
               if (exp_r.size() != 0) begin
                  e = exp_r.pop_front();
                  check("rbeat", {29'd0, s_axi_rdata, s_axi_rresp, s_axi_rlast}, {29'd0, e});
               end
            end
         end
      end
   end

   initial begin : main
      int   n;
      logic hs;
      rst_n = 1'b0;
      s_axi_awaddr = '0; s_axi_awlen = '0; s_axi_awsize = '0; s_axi_awburst = '0; s_axi_awvalid = 1'b0;
      s_axi_araddr = '0; s_axi_arlen = '0; s_axi_arsize = '0; s_axi_arburst = '0; s_axi_arvalid = 1'b0;
      s_axi_awlock = 1'b0; s_axi_awcache = '0; s_axi_awprot = '0; s_axi_awqos = '0; s_axi_awregion = '0;
      s_axi_arlock = 1'b0; s_axi_arcache = '0; s_axi_arprot = '0; s_axi_arqos = '0; s_axi_arregion = '0;
      s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wlast = 1'b0; s_axi_wvalid = 1'b0;
      s_axi_bready = 1'b1;

      // reset values
      repeat (3) @(posedge Clk);
      @(negedge Clk);
      check("rst_awready", 64'(s_axi_awready), 64'd0);
      check("rst_arready", 64'(s_axi_arready), 64'd0);
      check("rst_wready",  64'(s_axi_wready),  64'd0);
      check("rst_bvalid",  64'(s_axi_bvalid),  64'd0);
      check("rst_rvalid",  64'(s_axi_rvalid),  64'd0);
      check("rst_rlast",   64'(s_axi_rlast),   64'd0);
      check("rst_bresp",   64'(s_axi_bresp),   64'd0);
      check("rst_rresp",   64'(s_axi_rresp),   64'd0);
      check("rst_rdata",   64'(s_axi_rdata),   64'd0);
      @(posedge Clk); #1;
      rst_n = 1'b1;
      @(posedge Clk); #1;
      @(negedge Clk);
      check("post_rst_awready", 64'(s_axi_awready), 64'd1);
      check("post_rst_arready", 64'(s_axi_arready), 64'd1);
      @(posedge Clk); #1;

      // single write / read with read latency
      write_burst(32'h10, 8'd0, 3'd2, BURST_INCR, 32'hDEADBEEF, 32'd0, 4'hF, 0, RESP_OKAY);
      push_r(32'hDEADBEEF, RESP_OKAY, 1'b1);
      ar_req(32'h10, 8'd0, 3'd2, BURST_INCR);
      @(negedge Clk); check("rd_lat_t1", 64'(s_axi_rvalid), 64'd0);
      @(negedge Clk); check("rd_lat_t2", 64'(s_axi_rvalid), 64'd1);
      @(posedge Clk); #1;
      wait_drain();

      // 256-beat INCR write and full-throughput read
      write_burst(32'h100, 8'd255, 3'd2, BURST_INCR, 32'd0, 32'd1, 4'hF, 255, RESP_OKAY);
      for (int i = 0; i < 256; i++) push_r(32'(i), RESP_OKAY, i == 255);
      ar_req(32'h100, 8'd255, 3'd2, BURST_INCR);
      n = 0; hs = 1'b0;
      while (!hs && n < TMO) begin
         @(negedge Clk); n++;
         hs = s_axi_rvalid && s_axi_rready && s_axi_rlast;
      end
      check("burst256_span", 64'(n), 64'd257);
      @(posedge Clk); #1;
      wait_drain();

      // 8-beat read under 1,0,0,1 backpressure
      rr_mode = 1'b1;
      for (int i = 0; i < 8; i++) push_r(32'(i), RESP_OKAY, i == 7);
      ar_req(32'h100, 8'd7, 3'd2, BURST_INCR);
      wait_drain();
      rr_mode = 1'b0;

      // early wlast on beat 1 of 4: all beats land, response SLVERR
      write_burst(32'h200, 8'd3, 3'd2, BURST_INCR, 32'hA0, 32'd1, 4'hF, 1, RESP_SLVERR);
      for (int i = 0; i < 4; i++) push_r(32'hA0 + 32'(i), RESP_OKAY, i == 3);
      ar_req(32'h200, 8'd3, 3'd2, BURST_INCR);
      wait_drain();

      // simultaneous AW/AR twice: write first, then read (sees the write), then write
      exp_b.push_back(RESP_OKAY);
      exp_b.push_back(RESP_OKAY);
      push_r(32'h12345678, RESP_OKAY, 1'b1);
      s_axi_awaddr = 32'h300; s_axi_awlen = 8'd0; s_axi_awsize = 3'd2; s_axi_awburst = BURST_INCR;
      s_axi_araddr = 32'h300; s_axi_arlen = 8'd0; s_axi_arsize = 3'd2; s_axi_arburst = BURST_INCR;
      s_axi_awvalid = 1'b1; s_axi_arvalid = 1'b1;
      @(negedge Clk);
      check("arb1_awready", 64'(s_axi_awready), 64'd1);
      check("arb1_arready", 64'(s_axi_arready), 64'd0);
      @(posedge Clk); #1;
      s_axi_awvalid = 1'b0;
      w_burst(1, 32'h12345678, 32'd0, 4'hF, 0);
      s_axi_awaddr = 32'h304; s_axi_awvalid = 1'b1;
      n = 0; hs = 1'b0;
      while (!hs && n < TMO) begin
         @(negedge Clk);
         hs = s_axi_awready || s_axi_arready;
         if (hs) begin
            check("arb2_arready", 64'(s_axi_arready), 64'd1);
            check("arb2_awready", 64'(s_axi_awready), 64'd0);
         end
         @(posedge Clk); #1; n++;
      end
      check("arb2_seen", 64'(hs), 64'd1);
      s_axi_arvalid = 1'b0;
      aw_req(32'h304, 8'd0, 3'd2, BURST_INCR);
      w_burst(1, 32'h55, 32'd0, 4'hF, 0);
      wait_drain();

      // WRAP read, len=3 from 0x08
      write_burst(32'h0, 8'd3, 3'd2, BURST_INCR, 32'h100, 32'd1, 4'hF, 3, RESP_OKAY);
`ifdef AXI_BURST_RAM_WRAP_EN
      push_r(32'h102, RESP_OKAY, 1'b0);
      push_r(32'h103, RESP_OKAY, 1'b0);
      push_r(32'h100, RESP_OKAY, 1'b0);
      push_r(32'h101, RESP_OKAY, 1'b1);
`else
      for (int i = 0; i < 4; i++) push_r(32'd0, RESP_SLVERR, i == 3);
`endif
      ar_req(32'h08, 8'd3, 3'd2, BURST_WRAP);
      wait_drain();

      // size>2 write is rejected without touching RAM
      write_burst(32'h0, 8'd0, 3'd3, BURST_INCR, 32'hFFFFFFFF, 32'd0, 4'hF, 0, RESP_SLVERR);
      push_r(32'h100, RESP_OKAY, 1'b1);
      ar_req(32'h0, 8'd0, 3'd2, BURST_INCR);
      wait_drain();

      // reserved burst type: beat count honoured, SLVERR, zero data
      push_r(32'd0, RESP_SLVERR, 1'b0);
      push_r(32'd0, RESP_SLVERR, 1'b1);
      ar_req(32'h0, 8'd1, 3'd2, 2'b11);
      wait_drain();

      // narrow byte write, read back through an aliased address
      write_burst(32'h11, 8'd0, 3'd0, BURST_INCR, 32'h0000AA00, 32'd0, 4'b0010, 0, RESP_OKAY);
      push_r(32'hDEADAAEF, RESP_OKAY, 1'b1);
      ar_req(32'h4010, 8'd0, 3'd2, BURST_INCR);
      wait_drain();

      // FIXED write then FIXED read: same word every beat
      write_burst(32'h20, 8'd1, 3'd2, BURST_FIXED, 32'd1, 32'd1, 4'hF, 1, RESP_OKAY);
      push_r(32'd2, RESP_OKAY, 1'b0);
      push_r(32'd2, RESP_OKAY, 1'b1);
      ar_req(32'h20, 8'd1, 3'd2, BURST_FIXED);
      wait_drain();

      repeat (4) @(posedge Clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
